// File: rtl/issuer_pkg.sv
// Shared types and packed issue-word layout for the inst_issuer_rs slice.
// Optional ISSUER_CDB_BYPASS_EN lets the head issue on the resolving CDB cycle.
package issuer_pkg;

  localparam int FN_W  = 2;
  localparam int OPR_W = 4;
  localparam int OPD_W = 2;
  localparam int IMM_W = 32;
  localparam int REG_W = 5;
  localparam int PC_W  = 32;

  typedef enum logic [FN_W-1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_BPU = 2'd2,
    FU_CSR = 2'd3
  } fu_e;

  // Packed word, LSB first: cur_pc, nxt_pc, taken, rd_wen, rd, rs2, rs1,
  // imm, operand, operator, function.
  localparam int CPC_OFF = 0;
  localparam int NPC_OFF = CPC_OFF + PC_W;
  localparam int TKN_OFF = NPC_OFF + PC_W;
  localparam int RDW_OFF = TKN_OFF + 1;
  localparam int RD_OFF  = RDW_OFF + 1;
  localparam int RS2_OFF = RD_OFF + REG_W;
  localparam int RS1_OFF = RS2_OFF + REG_W;
  localparam int IMM_OFF = RS1_OFF + REG_W;
  localparam int OPD_OFF = IMM_OFF + IMM_W;
  localparam int OPR_OFF = OPD_OFF + OPD_W;
  localparam int FN_OFF  = OPR_OFF + OPR_W;
  localparam int PAYLOAD_W = FN_OFF + FN_W;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 2;

  typedef struct packed {
    logic              ready;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } opnd_t;

  function automatic logic [FN_W-1:0] pl_fn(
    input logic [PAYLOAD_W-1:0] p
  );
    return p[FN_OFF +: FN_W];
  endfunction

endpackage

// File: rtl/issuer_operand_slot.sv
// One source-operand slot: fetch-time capture plus CDB wakeup.
// ISSUER_CDB_BYPASS_EN exposes a broadcast resolving this slot immediately.
module issuer_operand_slot
  import issuer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ld_pend,
  input  logic [TAG_W-1:0]  ld_alias,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              watch,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_id,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              rdy_o,
  output logic [DATA_W-1:0] data_o
);

  opnd_t slot_q, slot_d;
  logic  ld_hit;
  logic  tag_hit;
  logic  wk_hit;

  always_comb begin
    ld_hit  = cdb_valid && (cdb_id == ld_alias);
    tag_hit = watch && !slot_q.ready && cdb_valid
              && (cdb_id == slot_q.tag);
    wk_hit  = tag_hit && !load;
    slot_d  = slot_q;
    unique case (1'b1)
      load: begin
        slot_d.tag = ld_alias;
        if (!ld_pend) begin
          slot_d.ready = 1'b1;
          slot_d.data  = ld_data;
        end else if (ld_hit) begin
          slot_d.ready = 1'b1;
          slot_d.data  = cdb_data;
        end else begin
          slot_d.ready = 1'b0;
        end
      end
      wk_hit: begin
        slot_d.ready = 1'b1;
        slot_d.data  = cdb_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

`ifdef ISSUER_CDB_BYPASS_EN
  assign rdy_o  = slot_q.ready || tag_hit;
  assign data_o = slot_q.ready ? slot_q.data : cdb_data;
`else
  assign rdy_o  = slot_q.ready;
  assign data_o = slot_q.data;
`endif

endmodule

// File: rtl/inst_issuer_rs.sv
// In-order dispatch buffer feeding FU_NUM function units from the issue queue.
// ISSUER_CDB_BYPASS_EN (in issuer_operand_slot) enables same-cycle CDB issue.
module inst_issuer_rs
  import issuer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int FU_NUM     = 4,
  parameter int ARCH_ENTRY = 32,
  parameter int ROB_ENTRY  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PAYLOAD_W  = issuer_pkg::PAYLOAD_W,
  localparam int AW = $clog2(ARCH_ENTRY),
  localparam int RW = $clog2(ROB_ENTRY),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iq_rok,
  input  logic [PAYLOAD_W-1:0]  iq_rdata,
  output logic                  iq_ren,
  output logic [AW-1:0]         rat_rs1_id,
  output logic [AW-1:0]         rat_rs2_id,
  input  logic                  rat_rs1_busy,
  input  logic                  rat_rs2_busy,
  input  logic [RW-1:0]         rat_rs1_alias,
  input  logic [RW-1:0]         rat_rs2_alias,
  output logic [AW-1:0]         rf_rs1_id,
  output logic [AW-1:0]         rf_rs2_id,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  output logic                  rob_request,
  output logic [AW-1:0]         rob_arch_id,
  input  logic                  rob_grant,
  input  logic [RW-1:0]         rob_alias_id,
  input  logic                  cdb_valid,
  input  logic [RW-1:0]         cdb_id,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic [FU_NUM-1:0]     fu_wok,
  input  logic                  flush,
  output logic                  isr_valid,
  output logic [FU_NUM-1:0]     isr_fu_sel,
  output logic [PAYLOAD_W-1:0]  isr_payload,
  output logic [DATA_WIDTH-1:0] isr_rs1_data,
  output logic [DATA_WIDTH-1:0] isr_rs2_data,
  output logic [RW-1:0]         isr_rob_entry,
  output logic [OW-1:0]         occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0]  pl_q  [DEPTH];
  logic [PAYLOAD_W-1:0]  pl_d  [DEPTH];
  logic [RW-1:0]         rob_q [DEPTH];
  logic [RW-1:0]         rob_d [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [OW-1:0]         occ_q, occ_d;

  logic [DEPTH-1:0]      ld;
  logic [DEPTH-1:0]      rdy1, rdy2;
  logic [DATA_WIDTH-1:0] dat1 [DEPTH];
  logic [DATA_WIDTH-1:0] dat2 [DEPTH];

  logic [AW-1:0]         rs1, rs2;
  logic                  pend1, pend2;
  logic [FN_W-1:0]       head_fn;
  logic                  fu_ok;
  logic                  issue;
  logic                  space;
  logic                  fetch;

  assign rs1 = iq_rdata[RS1_OFF +: REG_W];
  assign rs2 = iq_rdata[RS2_OFF +: REG_W];

  assign rat_rs1_id  = rs1;
  assign rat_rs2_id  = rs2;
  assign rf_rs1_id   = rs1;
  assign rf_rs2_id   = rs2;
  assign rob_arch_id = iq_rdata[RD_OFF +: REG_W];

  // x0 never waits on a producer regardless of what the RAT reports
  assign pend1 = rat_rs1_busy && (rs1 != '0);
  assign pend2 = rat_rs2_busy && (rs2 != '0);

  assign head_fn = pl_fn(pl_q[head_q]);
  assign fu_ok   = (int'(head_fn) < FU_NUM)
                   && fu_wok[head_fn];

  assign issue = !RST && vld_q[head_q]
                 && rdy1[head_q] && rdy2[head_q]
                 && fu_ok;

  assign space       = (occ_q < OW'(DEPTH)) || issue;
  assign rob_request = !RST && iq_rok && space && !flush;
  assign fetch       = rob_request && rob_grant;
  assign iq_ren      = fetch;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ld[i] = fetch && (tail_q == PW'(i));

    issuer_operand_slot u_src1 (
      .clk       (CLK),
      .rst       (RST),
      .load      (ld[i]),
      .ld_pend   (pend1),
      .ld_alias  (rat_rs1_alias),
      .ld_data   (rf_rs1_data),
      .watch     (vld_q[i]),
      .cdb_valid (cdb_valid),
      .cdb_id    (cdb_id),
      .cdb_data  (cdb_data),
      .rdy_o     (rdy1[i]),
      .data_o    (dat1[i])
    );

    issuer_operand_slot u_src2 (
      .clk       (CLK),
      .rst       (RST),
      .load      (ld[i]),
      .ld_pend   (pend2),
      .ld_alias  (rat_rs2_alias),
      .ld_data   (rf_rs2_data),
      .watch     (vld_q[i]),
      .cdb_valid (cdb_valid),
      .cdb_id    (cdb_id),
      .cdb_data  (cdb_data),
      .rdy_o     (rdy2[i]),
      .data_o    (dat2[i])
    );
  end

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    pl_d   = pl_q;
    rob_d  = rob_q;
    // issue before fetch so a full buffer can refill the slot it frees
    if (issue) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (fetch) begin
      vld_d[tail_q] = 1'b1;
      pl_d[tail_q]  = iq_rdata;
      rob_d[tail_q] = rob_alias_id;
      tail_d        = tail_q + PW'(1);
    end
    case ({fetch, issue})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: ;
    endcase
    if (flush) begin
      vld_d  = '0;
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pl_q[i]  <= '0;
        rob_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      pl_q   <= pl_d;
      rob_q  <= rob_d;
    end
  end

  assign isr_valid     = issue;
  assign isr_fu_sel    = issue ? (FU_NUM'(1) << head_fn) : '0;
  assign isr_payload   = issue ? pl_q[head_q] : '0;
  assign isr_rs1_data  = issue ? dat1[head_q] : '0;
  assign isr_rs2_data  = issue ? dat2[head_q] : '0;
  assign isr_rob_entry = issue ? rob_q[head_q] : '0;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_inst_issuer_rs.sv
// Scoreboard bench for inst_issuer_rs: directed fetches queue expected issues.
// Build with ISSUER_CDB_BYPASS_EN defined to check the one-cycle-earlier issue.
module tb_inst_issuer_rs;
  import issuer_pkg::*;

`ifdef ISSUER_CDB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 iq_rok;
  logic [PAYLOAD_W-1:0] iq_rdata;
  logic                 iq_ren;
  logic [4:0]           rat_rs1_id, rat_rs2_id;
  logic                 rat_rs1_busy, rat_rs2_busy;
  logic [1:0]           rat_rs1_alias, rat_rs2_alias;
  logic [4:0]           rf_rs1_id, rf_rs2_id;
  logic [31:0]          rf_rs1_data, rf_rs2_data;
  logic                 rob_request;
  logic [4:0]           rob_arch_id;
  logic                 rob_grant;
  logic [1:0]           rob_alias_id;
  logic                 cdb_valid;
  logic [1:0]           cdb_id;
  logic [31:0]          cdb_data;
  logic [3:0]           fu_wok;
  logic                 flush;
  logic                 isr_valid;
  logic [3:0]           isr_fu_sel;
  logic [PAYLOAD_W-1:0] isr_payload;
  logic [31:0]          isr_rs1_data, isr_rs2_data;
  logic [1:0]           isr_rob_entry;
  logic [2:0]           occupancy;

  inst_issuer_rs dut (
    .CLK           (CLK),
    .RST           (RST),
    .iq_rok        (iq_rok),
    .iq_rdata      (iq_rdata),
    .iq_ren        (iq_ren),
    .rat_rs1_id    (rat_rs1_id),
    .rat_rs2_id    (rat_rs2_id),
    .rat_rs1_busy  (rat_rs1_busy),
    .rat_rs2_busy  (rat_rs2_busy),
    .rat_rs1_alias (rat_rs1_alias),
    .rat_rs2_alias (rat_rs2_alias),
    .rf_rs1_id     (rf_rs1_id),
    .rf_rs2_id     (rf_rs2_id),
    .rf_rs1_data   (rf_rs1_data),
    .rf_rs2_data   (rf_rs2_data),
    .rob_request   (rob_request),
    .rob_arch_id   (rob_arch_id),
    .rob_grant     (rob_grant),
    .rob_alias_id  (rob_alias_id),
    .cdb_valid     (cdb_valid),
    .cdb_id        (cdb_id),
    .cdb_data      (cdb_data),
    .fu_wok        (fu_wok),
    .flush         (flush),
    .isr_valid     (isr_valid),
    .isr_fu_sel    (isr_fu_sel),
    .isr_payload   (isr_payload),
    .isr_rs1_data  (isr_rs1_data),
    .isr_rs2_data  (isr_rs2_data),
    .isr_rob_entry (isr_rob_entry),
    .occupancy     (occupancy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int                   cyc;
    logic [3:0]           sel;
    logic [31:0]          d1;
    logic [31:0]          d2;
    logic [1:0]           rob;
    logic [PAYLOAD_W-1:0] pl;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [PAYLOAD_W-1:0] mk(
    input logic [1:0]  fn,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  rd,
    input logic [31:0] imm
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[FN_OFF +: FN_W]   = fn;
    p[IMM_OFF +: IMM_W] = imm;
    p[RS1_OFF +: REG_W] = r1;
    p[RS2_OFF +: REG_W] = r2;
    p[RD_OFF +: REG_W]  = rd;
    p[RDW_OFF]          = 1'b1;
    p[CPC_OFF +: PC_W]  = imm << 2;
    p[NPC_OFF +: PC_W]  = (imm << 2) + 32'd4;
    return p;
  endfunction

  task automatic expect_issue(input int c,
                              input logic [1:0] fn,
                              input logic [31:0] a,
                              input logic [31:0] b,
                              input logic [1:0] r,
                              input logic [PAYLOAD_W-1:0] p);
    exp_t e;
    e.cyc = c;
    e.sel = 4'b0001 << fn;
    e.d1  = a;
    e.d2  = b;
    e.rob = r;
    e.pl  = p;
    sbq.push_back(e);
  endtask

  task automatic idle();
    iq_rok        = 1'b0;
    iq_rdata      = '0;
    rat_rs1_busy  = 1'b0;
    rat_rs2_busy  = 1'b0;
    rat_rs1_alias = '0;
    rat_rs2_alias = '0;
    rf_rs1_data   = '0;
    rf_rs2_data   = '0;
    rob_grant     = 1'b1;
    rob_alias_id  = '0;
    cdb_valid     = 1'b0;
    cdb_id        = '0;
    cdb_data      = '0;
    fu_wok        = 4'hF;
    flush         = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int t;
    logic [PAYLOAD_W-1:0] p;
    logic [PAYLOAD_W-1:0] pv [5];
    exp_t e;

    idle();
    RST = 1'b1;
    iq_rok = 1'b1;
    iq_rdata = mk(FU_ALU, 5'd1, 5'd2, 5'd3, 32'd99);

    fork
      forever begin
        @(negedge CLK);
        if (isr_valid === 1'b1) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue cyc=%0d pl=%0h",
                     cyc, isr_payload);
          end else begin
            e = sbq.pop_front();
            chk("iss_cyc", cyc, e.cyc);
            chk("iss_sel", isr_fu_sel, e.sel);
            chk("iss_rs1", isr_rs1_data, e.d1);
            chk("iss_rs2", isr_rs2_data, e.d2);
            chk("iss_rob", isr_rob_entry, e.rob);
            chk("iss_pl", isr_payload, e.pl);
          end
        end else begin
          chk("idle_sel", isr_fu_sel, 4'd0);
        end
      end
    join_none

    fork
      begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
      end
    join_none

    // reset holds everything quiet even with iq_rok high
    tick();
    tick();
    #3;
    chk("rst_iq_ren", iq_ren, 1'b0);
    chk("rst_rob_req", rob_request, 1'b0);
    chk("rst_valid", isr_valid, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_pl", isr_payload, '0);
    tick();
    RST = 1'b0;
    idle();

    // independent ALU op
    tick();
    t = cyc;
    p = mk(FU_ALU, 5'd1, 5'd2, 5'd3, 32'd1);
    iq_rok = 1'b1;
    iq_rdata = p;
    rf_rs1_data = 32'd5;
    rf_rs2_data = 32'd7;
    rob_alias_id = 2'd1;
    expect_issue(t + 1, FU_ALU, 32'd5, 32'd7, 2'd1, p);
    #3;
    chk("t1_iq_ren", iq_ren, 1'b1);
    chk("t1_rat_id", rat_rs1_id, 5'd1);
    chk("t1_rf_id2", rf_rs2_id, 5'd2);
    chk("t1_rob_arch", rob_arch_id, 5'd3);
    tick();
    idle();
    tick();
    tick();

    // RAW on rs1, wrong-tag broadcast ignored
    tick();
    t = cyc;
    p = mk(FU_LSU, 5'd4, 5'd5, 5'd6, 32'd2);
    iq_rok = 1'b1;
    iq_rdata = p;
    rat_rs1_busy = 1'b1;
    rat_rs1_alias = 2'd2;
    rf_rs1_data = 32'h1111;
    rf_rs2_data = 32'd9;
    rob_alias_id = 2'd0;
    expect_issue(t + 4 - BYP, FU_LSU, 32'hDEAD, 32'd9, 2'd0, p);
    tick();
    idle();
    cdb_valid = 1'b1;
    cdb_id = 2'd3;
    cdb_data = 32'hBAD;
    tick();
    idle();
    #3;
    chk("t2_wait", isr_valid, 1'b0);
    tick();
    cdb_valid = 1'b1;
    cdb_id = 2'd2;
    cdb_data = 32'hDEAD;
    tick();
    idle();
    tick();
    tick();

    // CDB hit during fetch; rs2 = x0 ignores RAT busy
    tick();
    t = cyc;
    p = mk(FU_BPU, 5'd7, 5'd0, 5'd8, 32'd3);
    iq_rok = 1'b1;
    iq_rdata = p;
    rat_rs1_busy = 1'b1;
    rat_rs1_alias = 2'd1;
    rat_rs2_busy = 1'b1;
    rat_rs2_alias = 2'd2;
    rf_rs1_data = 32'h3333;
    rf_rs2_data = 32'h22;
    cdb_valid = 1'b1;
    cdb_id = 2'd1;
    cdb_data = 32'hCAFE;
    rob_alias_id = 2'd3;
    expect_issue(t + 1, FU_BPU, 32'hCAFE, 32'h22, 2'd3, p);
    tick();
    idle();
    tick();
    tick();

    // full buffer, other units ready but not ALU
    for (int i = 0; i < 5; i++) begin
      tick();
      pv[i] = mk(FU_ALU, 5'd1, 5'd2, 5'd9, 32'd16 + i);
      fu_wok = 4'b1110;
      iq_rok = 1'b1;
      iq_rdata = pv[i];
      rf_rs1_data = 32'h100 + i;
      rf_rs2_data = 32'h200 + i;
      rob_alias_id = 2'(i);
      #3;
      chk("t4_iq_ren", iq_ren, (i < 4));
      if (i == 4) begin
        chk("t4_full_occ", occupancy, 3'd4);
        chk("t4_full_req", rob_request, 1'b0);
      end
    end
    tick();
    t = cyc;
    fu_wok = 4'b0001;
    for (int i = 0; i < 5; i++)
      expect_issue(t + i, FU_ALU, 32'h100 + i, 32'h200 + i,
                   2'(i), pv[i]);
    #3;
    chk("t4_refill", iq_ren, 1'b1);
    tick();
    idle();
    #3;
    chk("t4_occ_hold", occupancy, 3'd4);
    for (int i = 0; i < 5; i++) tick();
    #3;
    chk("t4_drained", occupancy, 3'd0);

    // ROB stall, grant two cycles later
    tick();
    t = cyc;
    p = mk(FU_CSR, 5'd3, 5'd4, 5'd5, 32'd40);
    iq_rok = 1'b1;
    iq_rdata = p;
    rob_grant = 1'b0;
    rf_rs1_data = 32'h55;
    rf_rs2_data = 32'h66;
    rob_alias_id = 2'd2;
    #3;
    chk("t5_req", rob_request, 1'b1);
    chk("t5_noren", iq_ren, 1'b0);
    tick();
    #3;
    chk("t5_noren2", iq_ren, 1'b0);
    chk("t5_occ", occupancy, 3'd0);
    tick();
    rob_grant = 1'b1;
    expect_issue(t + 3, FU_CSR, 32'h55, 32'h66, 2'd2, p);
    #3;
    chk("t5_ren", iq_ren, 1'b1);
    tick();
    idle();
    tick();
    tick();

    // flush with three pending entries
    for (int i = 0; i < 3; i++) begin
      tick();
      iq_rok = 1'b1;
      iq_rdata = mk(FU_ALU, 5'd1, 5'd2, 5'd3, 32'd50 + i);
      rat_rs1_busy = 1'b1;
      rat_rs1_alias = 2'd2;
      rob_alias_id = 2'(i);
    end
    tick();
    idle();
    flush = 1'b1;
    iq_rok = 1'b1;
    iq_rdata = mk(FU_ALU, 5'd1, 5'd2, 5'd3, 32'd59);
    #3;
    chk("t6_occ3", occupancy, 3'd3);
    chk("t6_noren", iq_ren, 1'b0);
    chk("t6_noreq", rob_request, 1'b0);
    tick();
    idle();
    #3;
    chk("t6_occ0", occupancy, 3'd0);
    chk("t6_valid", isr_valid, 1'b0);
    tick();
    cdb_valid = 1'b1;
    cdb_id = 2'd2;
    cdb_data = 32'h77;
    tick();
    idle();
    tick();
    tick();
    tick();
    t = cyc;
    p = mk(FU_ALU, 5'd1, 5'd2, 5'd3, 32'd60);
    iq_rok = 1'b1;
    iq_rdata = p;
    rf_rs1_data = 32'hA;
    rf_rs2_data = 32'hB;
    rob_alias_id = 2'd1;
    expect_issue(t + 1, FU_ALU, 32'hA, 32'hB, 2'd1, p);
    tick();
    idle();
    tick();
    tick();

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      tick();
      iq_rok = 1'b1;
      iq_rdata = mk(FU_LSU, 5'd6, 5'd7, 5'd8, 32'd70 + i);
      rat_rs1_busy = 1'b1;
      rat_rs1_alias = 2'd1;
      rob_alias_id = 2'(i);
    end
    tick();
    idle();
    RST = 1'b1;
    iq_rok = 1'b1;
    #3;
    chk("t7_noren", iq_ren, 1'b0);
    chk("t7_noreq", rob_request, 1'b0);
    chk("t7_valid", isr_valid, 1'b0);
    tick();
    RST = 1'b0;
    idle();
    #3;
    chk("t7_occ0", occupancy, 3'd0);
    chk("t7_pl0", isr_payload, '0);
    tick();
    cdb_valid = 1'b1;
    cdb_id = 2'd1;
    cdb_data = 32'h88;
    tick();
    idle();
    tick();
    tick();
    tick();

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
